// File: rtl/puf_eval_ctrl_pkg.sv
// Shared definitions for the arbiter-PUF evaluation controller:
// FSM encodings, default timing constants and response-vote helpers.
package puf_defs;

  localparam int DEF_N             = 8;
  localparam int DEF_RST_CYCLES    = 2;
  localparam int DEF_SETTLE_CYCLES = 16;
  localparam int DEF_REPEATS       = 7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_GAP    = 3'd2,
    ST_FIRE   = 3'd3,
    ST_SAMPLE = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  function automatic logic maj_vote(input int ones, input int reps);
    return (ones > (reps / 2));
  endfunction

  function automatic logic all_agree(input int ones, input int reps);
    return (ones == 0) || (ones == reps);
  endfunction

endpackage

// File: rtl/puf_sync2.sv
// Two-flop synchronizer for the asynchronous arbiter output; clears to 0.
module puf_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  // Next-state of the two synchronizer stages.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer flops, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/puf_eval_ctrl.sv
// Sequencer for an arbiter PUF core: runs REPEATS clear/fire/sample
// evaluations per challenge and returns the majority vote with a stability flag.
module puf_eval_ctrl
  import puf_defs::*;
#(
  parameter int N             = DEF_N,
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int REPEATS       = DEF_REPEATS,
  parameter int CNT_W         = $clog2(REPEATS + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N-1:0]     chal_in,
  input  logic             chal_valid,
  output logic             chal_ready,
  output logic             resp_out,
  output logic             resp_stable,
  output logic [CNT_W-1:0] resp_ones,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [N-1:0]     puf_challenge,
  output logic             puf_reset,
  output logic             puf_start,
  input  logic             puf_out,
  output logic             busy
);

  localparam int TMR_W = $clog2(SETTLE_CYCLES + RST_CYCLES + 1);

  state_e             state_d, state_q;
  logic [TMR_W-1:0]   tmr_d, tmr_q;
  logic [CNT_W-1:0]   rep_d, rep_q;
  logic [CNT_W-1:0]   ones_d, ones_q;
  logic [N-1:0]       chal_d, chal_q;
  logic               resp_out_d, resp_out_q;
  logic               resp_stable_d, resp_stable_q;
  logic [CNT_W-1:0]   resp_ones_d, resp_ones_q;
  logic               resp_valid_d, resp_valid_q;
  logic               puf_reset_d, puf_reset_q;
  logic               puf_start_d, puf_start_q;
  logic               busy_d, busy_q;
  logic               puf_sync_s;

  puf_sync2 u_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (puf_out),
    .q     (puf_sync_s)
  );

  // Next-state, counters and response latch; pin levels follow the next state
  // so that every output comes straight from a flop.
  always_comb begin
    state_d       = state_q;
    tmr_d         = tmr_q;
    rep_d         = rep_q;
    ones_d        = ones_q;
    chal_d        = chal_q;
    resp_out_d    = resp_out_q;
    resp_stable_d = resp_stable_q;
    resp_ones_d   = resp_ones_q;
    case (state_q)
      ST_IDLE: begin
        tmr_d = {TMR_W{1'b0}};
        if (chal_valid) begin
          chal_d  = chal_in;
          rep_d   = {CNT_W{1'b0}};
          ones_d  = {CNT_W{1'b0}};
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (tmr_q == TMR_W'(RST_CYCLES - 1)) begin
          tmr_d   = {TMR_W{1'b0}};
          state_d = ST_GAP;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_GAP: begin
        tmr_d   = {TMR_W{1'b0}};
        state_d = ST_FIRE;
      end
      ST_FIRE: begin
        if (tmr_q == TMR_W'(SETTLE_CYCLES - 1)) begin
          tmr_d   = {TMR_W{1'b0}};
          state_d = ST_SAMPLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_SAMPLE: begin
        tmr_d  = {TMR_W{1'b0}};
        ones_d = ones_q + CNT_W'(puf_sync_s);
        rep_d  = rep_q + CNT_W'(1);
        if (rep_d < CNT_W'(REPEATS)) begin
          state_d = ST_CLEAR;
        end else begin
          state_d       = ST_DONE;
          resp_out_d    = maj_vote(int'(ones_d), REPEATS);
          resp_stable_d = all_agree(int'(ones_d), REPEATS);
          resp_ones_d   = ones_d;
        end
      end
      ST_DONE: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    puf_reset_d  = (state_d == ST_CLEAR);
    puf_start_d  = (state_d == ST_FIRE) || (state_d == ST_SAMPLE);
    resp_valid_d = (state_d == ST_DONE);
    busy_d       = (state_d != ST_IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      tmr_q         <= {TMR_W{1'b0}};
      rep_q         <= {CNT_W{1'b0}};
      ones_q        <= {CNT_W{1'b0}};
      chal_q        <= {N{1'b0}};
      resp_out_q    <= 1'b0;
      resp_stable_q <= 1'b0;
      resp_ones_q   <= {CNT_W{1'b0}};
      resp_valid_q  <= 1'b0;
      puf_reset_q   <= 1'b0;
      puf_start_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmr_q         <= tmr_d;
      rep_q         <= rep_d;
      ones_q        <= ones_d;
      chal_q        <= chal_d;
      resp_out_q    <= resp_out_d;
      resp_stable_q <= resp_stable_d;
      resp_ones_q   <= resp_ones_d;
      resp_valid_q  <= resp_valid_d;
      puf_reset_q   <= puf_reset_d;
      puf_start_q   <= puf_start_d;
      busy_q        <= busy_d;
    end
  end

  assign chal_ready    = (state_q == ST_IDLE);
  assign resp_out      = resp_out_q;
  assign resp_stable   = resp_stable_q;
  assign resp_ones     = resp_ones_q;
  assign resp_valid    = resp_valid_q;
  assign puf_challenge = chal_q;
  assign puf_reset     = puf_reset_q;
  assign puf_start     = puf_start_q;
  assign busy          = busy_q;

endmodule
